// File: rtl/tick_timer_ctrl.sv
// Shared-prescaler multi-channel countdown timer with valid/ready config port.
// Optional sticky expiry flags are enabled by defining TIMER_STICKY_EN.
module tick_timer_ctrl #(
    parameter int PRESCALE_MAX = 5_000_000 - 1,
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [1:0]                cfg_op,
    input  logic [CNT_W-1:0]          cfg_count,
    output logic                      tick_o,
    output logic [NUM_CH-1:0]         ch_busy,
    output logic [NUM_CH-1:0]         ch_expire
`ifdef TIMER_STICKY_EN
    ,
    output logic [NUM_CH-1:0]         ch_sticky
`endif
);

    localparam int CW = $clog2(NUM_CH);
    localparam int PW = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE_MAX);

    localparam logic [1:0] OP_STOP   = 2'b00;
    localparam logic [1:0] OP_ONE    = 2'b01;
    localparam logic [1:0] OP_PER    = 2'b10;
    localparam logic [1:0] OP_RELOAD = 2'b11;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    logic [PW-1:0]    pcnt;
    logic             accept;
    logic [CNT_W-1:0] cnt_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt   <= '0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= (pcnt == PMAX);
            pcnt   <= (pcnt == PMAX) ? '0 : pcnt + PW'(1);
        end
    end

    // No config in a tick cycle, so config and decrement never collide.
    assign cfg_ready = ~tick_o;
    assign accept    = cfg_valid & ~tick_o;
    assign cnt_eff   = (cfg_count == '0) ? CNT_W'(1) : cfg_count;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state;
        logic             periodic;
        logic [CNT_W-1:0] remaining;
        logic [CNT_W-1:0] reload;
        logic             exp_q;
        logic             hit;
        logic             fire;

        assign hit  = accept && (cfg_ch == CW'(i));
        assign fire = tick_o && (state == RUN) && (remaining == CNT_W'(1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                periodic  <= 1'b0;
                remaining <= '0;
                reload    <= '0;
                exp_q     <= 1'b0;
            end else begin
                exp_q <= 1'b0;
                if (hit) begin
                    unique case (cfg_op)
                        OP_STOP: begin
                            state     <= IDLE;
                            remaining <= '0;
                        end
                        OP_ONE, OP_PER: begin
                            state     <= RUN;
                            periodic  <= (cfg_op == OP_PER);
                            remaining <= cnt_eff;
                            reload    <= cnt_eff;
                        end
                        OP_RELOAD: begin
                            if (state == RUN) begin
                                remaining <= cnt_eff;
                                reload    <= cnt_eff;
                            end
                        end
                        default: ;
                    endcase
                end else if (tick_o && state == RUN) begin
                    if (remaining > CNT_W'(1)) begin
                        remaining <= remaining - CNT_W'(1);
                    end else begin
                        exp_q <= 1'b1;
                        if (periodic) begin
                            remaining <= reload;
                        end else begin
                            state     <= IDLE;
                            remaining <= '0;
                        end
                    end
                end
            end
        end

        assign ch_busy[i]   = (state == RUN);
        assign ch_expire[i] = exp_q;

`ifdef TIMER_STICKY_EN
        logic sticky_q;

        // Set has priority over a clear from an accepted config.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sticky_q <= 1'b0;
            end else if (fire) begin
                sticky_q <= 1'b1;
            end else if (hit) begin
                sticky_q <= 1'b0;
            end
        end

        assign ch_sticky[i] = sticky_q;
`endif
    end

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Directed bench for tick_timer_ctrl: vector table plus multi-cycle sequences.
module tb_tick_timer_ctrl;

    localparam int PM  = 4;
    localparam int NCH = 4;
    localparam int CNW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [1:0]      cfg_ch = '0;
    logic [1:0]      cfg_op = '0;
    logic [CNW-1:0]  cfg_count = '0;
    logic            tick_o;
    logic [NCH-1:0]  ch_busy;
    logic [NCH-1:0]  ch_expire;
`ifdef TIMER_STICKY_EN
    logic [NCH-1:0]  ch_sticky;
`endif

    tick_timer_ctrl #(
        .PRESCALE_MAX(PM),
        .NUM_CH(NCH),
        .CNT_W(CNW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_op(cfg_op),
        .cfg_count(cfg_count),
        .tick_o(tick_o),
        .ch_busy(ch_busy),
        .ch_expire(ch_expire)
`ifdef TIMER_STICKY_EN
        ,
        .ch_sticky(ch_sticky)
`endif
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic           v;
        logic [1:0]     ch;
        logic [1:0]     op;
        logic [CNW-1:0] cnt;
        logic           tick;
        logic           rdy;
        logic [3:0]     busy;
        logic [3:0]     exp;
    } vec_t;

    vec_t tv[1:17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [1:0] op,
                       input logic [CNW-1:0] cnt, output int e);
        int b;
        b = 0;
        while (!cfg_ready && b < 10) begin
            step();
            b++;
        end
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_op    = op;
        cfg_count = cnt;
        step();
        e = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_exp(input logic [3:0] m, input int budget,
                            input string nm, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if ((ch_expire & m) != 0) begin
                at = cyc;
                break;
            end
        end
        chk({nm, " timeout"}, 32'(at != -1), 32'd1);
    endtask

    function automatic int next_tick(input int e);
        return ((e + 4) / 5) * 5;
    endfunction

    initial begin
        int e, e0, at, at2, n, t;

        for (int c = 1; c <= 17; c++) begin
            tv[c] = '{v: 1'b0, ch: 2'd0, op: 2'd0, cnt: '0,
                      tick: 1'b0, rdy: 1'b1, busy: 4'b0000, exp: 4'b0000};
        end
        tv[2].v   = 1'b1;
        tv[2].op  = 2'b01;
        tv[2].cnt = 16'd3;
        for (int c = 2; c <= 15; c++) tv[c].busy = 4'b0001;
        tv[5].tick  = 1'b1; tv[5].rdy  = 1'b0;
        tv[10].tick = 1'b1; tv[10].rdy = 1'b0;
        tv[15].tick = 1'b1; tv[15].rdy = 1'b0;
        tv[16].exp  = 4'b0001;

        repeat (2) @(posedge clk);
        #1;
        chk("rst tick", 32'(tick_o), 32'd0);
        chk("rst ready", 32'(cfg_ready), 32'd1);
        chk("rst busy", 32'(ch_busy), 32'd0);
        chk("rst expire", 32'(ch_expire), 32'd0);
`ifdef TIMER_STICKY_EN
        chk("rst sticky", 32'(ch_sticky), 32'd0);
`endif
        #2 rst_n = 1'b1;

        // Tick cadence and a one-shot count=3 on ch0.
        for (int c = 1; c <= 17; c++) begin
            cfg_valid = tv[c].v;
            cfg_ch    = tv[c].ch;
            cfg_op    = tv[c].op;
            cfg_count = tv[c].cnt;
            step();
            chk($sformatf("v%0d tick", c), 32'(tick_o), 32'(tv[c].tick));
            chk($sformatf("v%0d ready", c), 32'(cfg_ready), 32'(tv[c].rdy));
            chk($sformatf("v%0d busy", c), 32'(ch_busy), 32'(tv[c].busy));
            chk($sformatf("v%0d expire", c), 32'(ch_expire), 32'(tv[c].exp));
        end
        cfg_valid = 1'b0;

        // Periodic ch1, count=2, then stop.
        cfg(2'd1, 2'b10, 16'd2, e);
        chk("per busy", 32'(ch_busy[1]), 32'd1);
        wait_exp(4'b0010, 30, "per exp1", at);
        chk("per exp1 cyc", 32'(at), 32'(next_tick(e) + 6));
        chk("per busy held", 32'(ch_busy[1]), 32'd1);
`ifdef TIMER_STICKY_EN
        chk("per sticky set", 32'(ch_sticky[1]), 32'd1);
`endif
        step();
        chk("per pulse width", 32'(ch_expire[1]), 32'd0);
        wait_exp(4'b0010, 30, "per exp2", at2);
        chk("per interval", 32'(at2 - at), 32'd10);
        cfg(2'd1, 2'b00, 16'd0, e);
        chk("stop busy", 32'(ch_busy[1]), 32'd0);
        n = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (ch_expire[1] || ch_busy[1]) n++;
        end
        chk("stop quiet", 32'(n), 32'd0);
`ifdef TIMER_STICKY_EN
        chk("stop sticky clr", 32'(ch_sticky[1]), 32'd0);
`endif

        // Count=0 acts as 1; reload while idle does nothing.
        cfg(2'd2, 2'b01, 16'd0, e);
        wait_exp(4'b0100, 15, "cnt0 exp", at);
        chk("cnt0 exp cyc", 32'(at), 32'(next_tick(e) + 1));
        chk("cnt0 busy", 32'(ch_busy[2]), 32'd0);
        cfg(2'd2, 2'b11, 16'd7, e);
        chk("reload idle busy", 32'(ch_busy[2]), 32'd0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ch_expire[2] || ch_busy[2]) n++;
        end
        chk("reload idle quiet", 32'(n), 32'd0);

        // cfg_valid held across a tick cycle.
        n = 0;
        while (!tick_o && n < 10) begin
            step();
            n++;
        end
        t = cyc;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_op    = 2'b01;
        cfg_count = 16'd1;
        chk("hold ready low", 32'(cfg_ready), 32'd0);
        step();
        chk("hold not taken", 32'(ch_busy[3]), 32'd0);
        step();
        chk("hold taken", 32'(ch_busy[3]), 32'd1);
        cfg_valid = 1'b0;
        wait_exp(4'b1000, 15, "hold exp", at);
        chk("hold exp cyc", 32'(at), 32'(t + 6));

        // Two channels started in the same tick window.
        n = 0;
        while ((cyc % 5) != 1 && n < 10) begin
            step();
            n++;
        end
        cfg(2'd0, 2'b01, 16'd2, e0);
        cfg(2'd3, 2'b01, 16'd2, e);
        wait_exp(4'b1001, 20, "pair exp", at);
        chk("pair both", 32'(ch_expire), 32'b1001);
        chk("pair cyc", 32'(at), 32'(next_tick(e0) + 6));

        // Reset in the middle of a periodic run.
        cfg(2'd0, 2'b10, 16'd1, e);
        wait_exp(4'b0001, 15, "pre-rst exp", at);
`ifdef TIMER_STICKY_EN
        chk("pre-rst sticky", 32'(ch_sticky[0]), 32'd1);
`endif
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst tick", 32'(tick_o), 32'd0);
        chk("mid-rst ready", 32'(cfg_ready), 32'd1);
        chk("mid-rst busy", 32'(ch_busy), 32'd0);
        chk("mid-rst expire", 32'(ch_expire), 32'd0);
`ifdef TIMER_STICKY_EN
        chk("mid-rst sticky", 32'(ch_sticky), 32'd0);
`endif
        #3 rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("post-rst tick c%0d", cyc), 32'(tick_o),
                32'((cyc % 5) == 0));
            if (ch_expire != 0 || ch_busy != 0) n++;
        end
        chk("post-rst quiet", 32'(n), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
